dac_step_sequencer: RTL

- Parametrised multi-channel DAC voltage-step sequencer; next generation of the single-channel button-driven step FSM.
- Owns the code register, step arithmetic and dwell timer internally.
- Drives an existing SPI write master through a start/end-of-write handshake.
- Sits between the user control registers and the DAC SPI master in the bolometer bias path.

---
 rtl/dac_seq_pkg.sv | 19 +
 rtl/dac_seq_ch_sel.sv | 25 ++
 rtl/dac_step_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and encodings for the multi-channel DAC step sequencer.
package dac_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WRITE    = 3'd2,
    S_WAIT_EOW = 3'd3,
    S_NEXT_CH  = 3'd4,
    S_DWELL    = 3'd5,
    S_STEP     = 3'd6
  } seq_state_e;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_TRI    = 2'd1;
  localparam logic [1:0] MODE_SAW    = 2'd2;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

endpackage : dac_seq_pkg

// File: rtl/dac_seq_ch_sel.sv
// Channel selector: finds the next set mask bit above the pointer, or the
// lowest set bit when from_lowest is high.
module dac_seq_ch_sel #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  input  logic              from_lowest,
  output logic [CH_W-1:0]   idx_c,
  output logic              valid_c
);

  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!valid_c && mask[i] && (from_lowest || (CH_W'(i) > ptr))) begin
        idx_c   = CH_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule : dac_seq_ch_sel

// File: rtl/dac_step_sequencer.sv
// Multi-channel DAC voltage-step sequencer: walks a code through ramp,
// triangle, sawtooth or single-write patterns and issues SPI writes per channel.
module dac_step_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DWELL_W = 24,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [NUM_CH-1:0]  ch_mask_i,
  input  logic [DATA_W-1:0]  code_start_i,
  input  logic [DATA_W-1:0]  code_stop_i,
  input  logic [DATA_W-1:0]  step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               eow_i,
  output logic               spi_start_o,
  output logic [DATA_W-1:0]  spi_data_o,
  output logic [CH_W-1:0]    spi_ch_o,
  output logic               busy_o,
  output logic               eov_o,
  output logic               done_o,
  output logic               err_o
);

  seq_state_e         state_q, state_d;
  logic [DATA_W-1:0]  code_q, code_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic               dir_up_q, dir_up_d;
  logic [1:0]         mode_q, mode_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]  start_q, start_d;
  logic [DATA_W-1:0]  stop_q, stop_d;
  logic [DATA_W-1:0]  step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_c, err_c;

  logic [NUM_CH-1:0]  sel_mask;
  logic               sel_lowest;
  logic [CH_W-1:0]    sel_idx_c;
  logic               sel_valid_c;

  logic [DATA_W:0]    sum_w, diff_w;
  logic [DATA_W-1:0]  up_next, dn_next;

  // LOAD sees the incoming mask; STEP restarts from the lowest latched channel
  assign sel_mask   = (state_q == S_LOAD) ? ch_mask_i : mask_q;
  assign sel_lowest = (state_q == S_LOAD) || (state_q == S_STEP);

  dac_seq_ch_sel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_ch_sel (
    .mask        (sel_mask),
    .ptr         (ptr_q),
    .from_lowest (sel_lowest),
    .idx_c       (sel_idx_c),
    .valid_c     (sel_valid_c)
  );

  // Step arithmetic with one guard bit; results clamp into [start, stop]
  assign sum_w   = {1'b0, code_q} + {1'b0, step_q};
  assign diff_w  = {1'b0, code_q} - {1'b0, step_q};
  assign up_next = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[DATA_W-1:0];
  assign dn_next = (diff_w[DATA_W] || (diff_w[DATA_W-1:0] < start_q)) ?
                   start_q : diff_w[DATA_W-1:0];

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    dir_up_d = dir_up_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    done_c   = 1'b0;
    err_c    = 1'b0;

    if ((state_q != S_IDLE) && abort_i) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((ch_mask_i != '0) && (code_start_i <= code_stop_i)) begin
            state_d = S_LOAD;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      S_LOAD: begin
        mode_d   = mode_i;
        mask_d   = ch_mask_i;
        start_d  = code_start_i;
        stop_d   = code_stop_i;
        step_d   = (step_i == '0) ? DATA_W'(1) : step_i;
        dwell_d  = dwell_i;
        code_d   = code_start_i;
        dir_up_d = 1'b1;
        ptr_d    = sel_idx_c;
        if (abort_i) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_WAIT_EOW;
      S_WAIT_EOW: begin
        if (eow_i) state_d = S_NEXT_CH;
      end
      S_NEXT_CH: begin
        if (sel_valid_c) begin
          ptr_d   = sel_idx_c;
          state_d = S_WRITE;
        end else if (abort_q || (mode_q == MODE_SINGLE)) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end else if (dwell_q == '0) begin
          state_d = S_STEP;
        end else begin
          cnt_d   = dwell_q;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        if (abort_i || abort_q) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end else if (cnt_q == DWELL_W'(1)) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        ptr_d   = sel_idx_c;
        state_d = S_WRITE;
        if (abort_i || abort_q) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end else begin
          unique case (mode_q)
            MODE_RAMP: begin
              if (code_q == stop_q) begin
                state_d = S_IDLE;
                done_c  = 1'b1;
              end else begin
                code_d = up_next;
              end
            end
            MODE_TRI: begin
              // A degenerate triangle (start==stop) ends after its single step
              if (code_q == start_q && (!dir_up_q || code_q == stop_q)) begin
                state_d = S_IDLE;
                done_c  = 1'b1;
              end else if (!dir_up_q || (code_q == stop_q)) begin
                dir_up_d = 1'b0;
                code_d   = dn_next;
              end else begin
                code_d = up_next;
              end
            end
            MODE_SAW: begin
              code_d = (code_q == stop_q) ? start_q : up_next;
            end
            default: begin
              state_d = S_IDLE;
              done_c  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      dir_up_q    <= 1'b1;
      mode_q      <= MODE_RAMP;
      mask_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      spi_start_o <= 1'b0;
      busy_o      <= 1'b0;
      eov_o       <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      dir_up_q    <= dir_up_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      spi_start_o <= (state_d == S_WRITE);
      busy_o      <= (state_d != S_IDLE);
      eov_o       <= (state_d == S_IDLE);
      done_o      <= done_c;
      err_o       <= err_c;
    end
  end

  assign spi_data_o = code_q;
  assign spi_ch_o   = ptr_q;

endmodule : dac_step_sequencer
